pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// MD_WAIT is only part of the state set when HAZARD_MULDIV_EN is defined.
package pipe_ctrl_pkg;

  localparam int REDIRECT_BUBBLES_DEF = 1;
  localparam int CNT_W_DEF            = 16;
  localparam int BCNT_W               = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
`ifdef HAZARD_MULDIV_EN
    REDIR    = 2'd2,
    MD_WAIT  = 2'd3
`else
    REDIR    = 2'd2
`endif
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
// Latency: count reflects inc one cycle later; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer (load-use, redirect, optional mul/div wait via HAZARD_MULDIV_EN).
// Controls are combinational from state and inputs (zero latency); event counters lag one cycle.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = REDIRECT_BUBBLES_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_use_hz,
  input  logic             redirect,
`ifdef HAZARD_MULDIV_EN
  input  logic             md_busy,
`endif
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [BCNT_W-1:0] BUBBLE_RELOAD = BCNT_W'(REDIRECT_BUBBLES - 1);
  localparam hz_state_e         REDIR_ENTRY   = (REDIRECT_BUBBLES > 1) ? REDIR : RUN;

  hz_state_e         state, state_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              md_req;
  logic              redirect_acc;

`ifdef HAZARD_MULDIV_EN
  assign md_req = md_busy;
`else
  assign md_req = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // A redirect always wins and restarts the bubble sequence from any state.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    if (redirect) begin
      state_nxt = REDIR_ENTRY;
      bcnt_nxt  = BUBBLE_RELOAD;
    end else begin
      case (state)
        RUN, LU_STALL: begin
`ifdef HAZARD_MULDIV_EN
          if (md_busy) begin
            state_nxt = MD_WAIT;
          end else
`endif
          if ((state == RUN) && load_use_hz) begin
            state_nxt = LU_STALL;
          end else begin
            state_nxt = RUN;
          end
        end
        REDIR: begin
          bcnt_nxt = bcnt - BCNT_W'(1);
          if (bcnt <= BCNT_W'(1)) begin
            state_nxt = RUN;
          end
        end
`ifdef HAZARD_MULDIV_EN
        MD_WAIT: begin
          if (!md_busy) begin
            state_nxt = RUN;
          end
        end
`endif
        default: begin
          state_nxt = RUN;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Gated by reset_n so an asserted reset silences the controls without waiting for an edge.
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    redirect_acc = 1'b0;
    if (reset_n) begin
      if (redirect) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        redirect_acc = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (md_req || load_use_hz) begin
              pc_hold    = 1'b1;
              ifid_hold  = 1'b1;
              idex_flush = 1'b1;
            end
          end
          LU_STALL: begin
            if (md_req) begin
              pc_hold    = 1'b1;
              ifid_hold  = 1'b1;
              idex_flush = 1'b1;
            end
          end
          REDIR: begin
            ifid_flush = 1'b1;
          end
`ifdef HAZARD_MULDIV_EN
          MD_WAIT: begin
            if (md_req) begin
              pc_hold    = 1'b1;
              ifid_hold  = 1'b1;
              idex_flush = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (pc_hold),
    .clear   (1'b0),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (redirect_acc),
    .clear   (1'b0),
    .count   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with REDIRECT_BUBBLES=2, CNT_W=4.
// Expected control bits are {pc_hold, ifid_hold, ifid_flush, idex_flush}.
module tb_pipeline_hazard_ctrl;

  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic [3:0]          ctrl;
    logic [TB_CNT_W-1:0] stall;
    logic [TB_CNT_W-1:0] flush;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  logic load_use_hz;
  logic redirect;
`ifdef HAZARD_MULDIV_EN
  logic md_busy;
`endif
  logic                pc_hold;
  logic                ifid_hold;
  logic                ifid_flush;
  logic                idex_flush;
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] flush_cnt;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .REDIRECT_BUBBLES (2),
    .CNT_W            (TB_CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_use_hz (load_use_hz),
    .redirect    (redirect),
`ifdef HAZARD_MULDIV_EN
    .md_busy     (md_busy),
`endif
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic drive(input logic rst, input logic lu, input logic rd,
                       input logic [3:0] ctrl, input int s, input int f);
    exp_t e;
    reset_n     = rst;
    load_use_hz = lu;
    redirect    = rd;
    e.ctrl  = ctrl;
    e.stall = TB_CNT_W'(s);
    e.flush = TB_CNT_W'(f);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic lu, input logic rd,
                      input logic [3:0] ctrl, input int s, input int f);
    @(posedge clock);
    #1;
    drive(rst, lu, rd, ctrl, s, f);
  endtask

`ifdef HAZARD_MULDIV_EN
  task automatic step_md(input logic md, input logic lu, input logic rd,
                         input logic [3:0] ctrl, input int s, input int f);
    @(posedge clock);
    #1;
    md_busy = md;
    drive(1'b1, lu, rd, ctrl, s, f);
  endtask
`endif

  // Monitor: one expected record per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {pc_hold, ifid_hold, ifid_flush, idex_flush};
        n_vec++;
        if (act !== e.ctrl || stall_cnt !== e.stall || flush_cnt !== e.flush) begin
          n_fail++;
          $display("FAIL vec%0d: got ctrl=%b stall=%0d flush=%0d, expected ctrl=%b stall=%0d flush=%0d",
                   n_vec, act, stall_cnt, flush_cnt, e.ctrl, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    load_use_hz = 1'b0;
    redirect    = 1'b0;
`ifdef HAZARD_MULDIV_EN
    md_busy     = 1'b0;
`endif
    // Reset holds everything at zero even with active inputs.
    step(0, 1, 1, 4'b0000, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(1, 0, 0, 4'b0000, 0, 0);
    // Load-use held two cycles: hold once, then one quiet LU_STALL cycle.
    step(1, 1, 0, 4'b1101, 0, 0);
    step(1, 1, 0, 4'b0000, 1, 0);
    step(1, 0, 0, 4'b0000, 1, 0);
    // Redirect pulse: two flush cycles, idex only in the first.
    step(1, 0, 1, 4'b0011, 1, 0);
    step(1, 0, 0, 4'b0010, 1, 1);
    step(1, 0, 0, 4'b0000, 1, 1);
    // Load-use coinciding with redirect: flush only, no hold.
    step(1, 1, 1, 4'b0011, 1, 1);
    step(1, 1, 0, 4'b0010, 1, 2);
    step(1, 0, 0, 4'b0000, 1, 2);
    // Back-to-back redirect reloads the bubble counter.
    step(1, 0, 1, 4'b0011, 1, 2);
    step(1, 0, 1, 4'b0011, 1, 3);
    step(1, 0, 0, 4'b0010, 1, 4);
    step(1, 0, 0, 4'b0000, 1, 4);
    // Redirect arriving during LU_STALL.
    step(1, 1, 0, 4'b1101, 1, 4);
    step(1, 0, 1, 4'b0011, 2, 4);
    step(1, 0, 0, 4'b0010, 2, 5);
    // Reset asserted mid-REDIR clears outputs and counters before the next edge.
    step(1, 0, 1, 4'b0011, 2, 5);
    step(0, 1, 1, 4'b0000, 0, 0);
    // First edge after release is evaluated from RUN.
    step(1, 1, 0, 4'b1101, 0, 0);
    step(1, 0, 0, 4'b0000, 1, 0);
    // Saturation: stall_cnt must stick at 15.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 4'b1101, (i + 1 > 15) ? 15 : i + 1, 0);
      step(1, 0, 0, 4'b0000, (i + 2 > 15) ? 15 : i + 2, 0);
    end
    step(1, 0, 0, 4'b0000, 15, 0);
    step(0, 0, 0, 4'b0000, 0, 0);
    step(1, 0, 0, 4'b0000, 0, 0);
`ifdef HAZARD_MULDIV_EN
    // md_busy for 5 cycles (beating load-use), then one quiet cycle.
    step_md(1, 1, 0, 4'b1101, 0, 0);
    step_md(1, 0, 0, 4'b1101, 1, 0);
    step_md(1, 1, 0, 4'b1101, 2, 0);
    step_md(1, 0, 0, 4'b1101, 3, 0);
    step_md(1, 0, 0, 4'b1101, 4, 0);
    step_md(0, 1, 0, 4'b0000, 5, 0);
    step_md(0, 0, 0, 4'b0000, 5, 0);
    // Redirect beats md_busy.
    step_md(1, 0, 1, 4'b0011, 5, 0);
    step_md(0, 0, 0, 4'b0010, 5, 1);
    step_md(0, 0, 0, 4'b0000, 5, 1);
`endif
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      @(negedge clock);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
